// File: rtl/spdif_pkg.sv
// spdif_pkg: preamble patterns, slot map and block length shared by the S/PDIF transmitter.
package spdif_pkg;
  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;
  localparam int SLOT_AUDIO_LO = 4;
  localparam int SLOT_V = 28;
  localparam int SLOT_U = 29;
  localparam int SLOT_C = 30;
  localparam int SLOT_P = 31;
  localparam int FRAMES_PER_BLOCK = 192;
  typedef enum logic {SUB_L = 1'b0, SUB_R = 1'b1} sub_t;
  function automatic logic [7:0] preamble(input sub_t sub, input logic block_first);
    return (sub == SUB_R) ? PRE_W : (block_first ? PRE_B : PRE_M);
  endfunction
endpackage

// File: rtl/spdif_bmc_encoder.sv
// spdif_bmc_encoder: biphase-mark line driver, one half-cell per tick.
module spdif_bmc_encoder (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic [5:0] i_hc,
  input  logic       i_bit,
  input  logic       i_pre,
  input  logic [7:0] i_pattern,
  output logic       o_line,
  output logic       o_nline
);
  logic r_line, r_nline, r_pol;
  logic w_pol, w_next;
  // Preamble polarity is the line level just before half-cell 0 of the subframe.
  always_comb begin
    w_pol  = (i_hc == 6'd0) ? r_line : r_pol;
    w_next = i_pre ? (i_pattern[~i_hc[2:0]] ^ w_pol) : (i_hc[0] ? (r_line ^ i_bit) : ~r_line);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_line  <= 1'b0;
      r_nline <= 1'b1;
      r_pol   <= 1'b0;
    end else if (i_tick) begin
      r_line  <= w_next;
      r_nline <= ~w_next;
      r_pol   <= w_pol;
    end
  end
  assign o_line  = r_line;
  assign o_nline = r_nline;
endmodule

// File: rtl/spdif_transmitter.sv
// spdif_transmitter: IEC 60958 consumer transmitter with Valid/Ready sample intake.
module spdif_transmitter
  import spdif_pkg::*;
#(
  parameter logic [39:0] CHANNEL_STATUS = 40'h0000_0200_04,
  parameter logic        USER_BIT       = 1'b0
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        Tick,
  input  logic [23:0] Left,
  input  logic [23:0] Right,
  input  logic        Valid,
  output logic        Ready,
  output logic        S_PDIF_Out,
  output logic        nS_PDIF,
  output logic        Frame_Start,
  output logic        Block_Start,
  output logic        Underrun
);
  logic [5:0]  r_hc;
  sub_t        r_sub;
  logic [7:0]  r_frame;
  logic        r_full, r_v, r_fs, r_bs, r_un;
  logic [23:0] r_hold_l, r_hold_r, r_sh_l, r_sh_r;
  logic        w_fs, w_load, w_c, w_par, w_bit, w_pre;
  logic [4:0]  w_slot, w_idx;
  logic [23:0] w_sample;
  logic [7:0]  w_pattern;
  always_comb begin
    w_fs      = Tick & (r_hc == 6'd0) & (r_sub == SUB_L);
    w_load    = Valid & ~r_full;
    w_slot    = r_hc[5:1];
    w_idx     = w_slot - 5'(SLOT_AUDIO_LO);
    w_sample  = (r_sub == SUB_R) ? r_sh_r : r_sh_l;
    w_c       = (r_frame < 8'd40) ? CHANNEL_STATUS[r_frame[5:0]] : 1'b0;
    w_par     = ^{w_sample, r_v, USER_BIT, w_c};
    w_pre     = w_slot < 5'(SLOT_AUDIO_LO);
    w_pattern = preamble(r_sub, r_frame == 8'd0);
    w_bit     = (w_slot == 5'(SLOT_V)) ? r_v :
                (w_slot == 5'(SLOT_U)) ? USER_BIT :
                (w_slot == 5'(SLOT_C)) ? w_c :
                (w_slot == 5'(SLOT_P)) ? w_par : w_sample[w_idx];
  end
  // A load on the frame-start edge lands in the holding register, so that frame underruns.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_hc     <= 6'd0;
      r_sub    <= SUB_L;
      r_frame  <= 8'd0;
      r_full   <= 1'b0;
      r_v      <= 1'b1;
      r_fs     <= 1'b0;
      r_bs     <= 1'b0;
      r_un     <= 1'b0;
      r_hold_l <= 24'd0;
      r_hold_r <= 24'd0;
      r_sh_l   <= 24'd0;
      r_sh_r   <= 24'd0;
    end else begin
      r_fs   <= w_fs;
      r_bs   <= w_fs & (r_frame == 8'd0);
      r_un   <= w_fs & ~r_full;
      r_full <= w_load | (r_full & ~w_fs);
      if (w_load) begin
        r_hold_l <= Left;
        r_hold_r <= Right;
      end
      if (w_fs) begin
        r_sh_l <= r_full ? r_hold_l : 24'd0;
        r_sh_r <= r_full ? r_hold_r : 24'd0;
        r_v    <= ~r_full;
      end
      if (Tick) begin
        r_hc <= r_hc + 6'd1;
        if (r_hc == 6'd63) begin
          r_sub <= (r_sub == SUB_L) ? SUB_R : SUB_L;
          if (r_sub == SUB_R)
            r_frame <= (r_frame == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : r_frame + 8'd1;
        end
      end
    end
  end
  spdif_bmc_encoder u_bmc (
    .i_clk     (Clk),
    .i_rst_n   (nReset),
    .i_tick    (Tick),
    .i_hc      (r_hc),
    .i_bit     (w_bit),
    .i_pre     (w_pre),
    .i_pattern (w_pattern),
    .o_line    (S_PDIF_Out),
    .o_nline   (nS_PDIF)
  );
  assign Ready       = ~r_full;
  assign Frame_Start = r_fs;
  assign Block_Start = r_bs;
  assign Underrun    = r_un;
endmodule
